// File: rtl/nmi_bus_arb_pkg.sv
// Shared types and constants for the two-master NMI bus arbiter.
// The optional transfer watchdog is enabled by defining NMI_BUS_ARB_TIMEOUT_EN.
package nmi_bus_arb_pkg;

    localparam int NMI_AW = 32;
    localparam int NMI_DW = 32;
    localparam int NMI_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_CPU = 2'd1,
        ST_OWN_DMA = 2'd2
    } arb_state_e;

    localparam int OWN_CPU_BIT = 0;
    localparam int OWN_DMA_BIT = 1;

    localparam logic [NMI_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi_bus_arb_if.sv
// Native memory interface bundle: request payload from master, ready/rdata back from slave.
interface nmi_if;
    import nmi_bus_arb_pkg::*;

    logic              valid;
    logic [NMI_AW-1:0] addr;
    logic [NMI_DW-1:0] wdata;
    logic [NMI_SW-1:0] wstrb;
    logic              ready;
    logic [NMI_DW-1:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/nmi_bus_arb_wdog.sv
// Wait-cycle watchdog for one granted transfer; expire pulses on the terminal wait cycle.
// Only instantiated when NMI_BUS_ARB_TIMEOUT_EN is defined.
module nmi_bus_arb_wdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic busy,
    input  logic done,
    output logic expire
);

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (start || done) begin
            cnt_reg <= '0;
        end else if (busy) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    // A ready on the terminal cycle keeps busy low, so it completes normally.
    assign expire = busy & (cnt_reg == LAST_CNT);

endmodule

// File: rtl/nmi_bus_arb.sv
// Round-robin arbiter sharing one NMI slave bus between the CPU and DMA masters.
// Define NMI_BUS_ARB_TIMEOUT_EN to terminate hung transfers with an error response.
module nmi_bus_arb
    import nmi_bus_arb_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYC = 1024,
    parameter logic [NMI_DW-1:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    nmi_if.slave              cpu,
    nmi_if.slave              dma,
    nmi_if.master             nmi,
    output logic [1:0]        grant_o,
    output logic              err_o,
    output logic [NMI_AW-1:0] err_addr_o,
    input  logic              err_clr_i
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] OWN_CPU = ST_OWN_CPU;
    localparam logic [1:0] OWN_DMA = ST_OWN_DMA;

    logic [1:0] state_reg, state_next;
    logic       last_dma_reg, last_dma_next;
    logic       own_cpu, own_dma;
    logic       x_valid;
    logic       leave;
    logic       expire;

    assign own_cpu = (state_reg == OWN_CPU);
    assign own_dma = (state_reg == OWN_DMA);
    assign x_valid = (own_cpu & cpu.valid) | (own_dma & dma.valid);

    // Leaving ownership: completion, timeout, or the owner withdrawing its request.
    assign leave = (own_cpu | own_dma) & (~x_valid | nmi.ready | expire);

    assign nmi.valid = x_valid & ~expire;
    assign nmi.addr  = own_dma ? dma.addr  : cpu.addr;
    assign nmi.wdata = own_dma ? dma.wdata : cpu.wdata;
    assign nmi.wstrb = own_dma ? dma.wstrb : cpu.wstrb;

    assign cpu.ready = own_cpu & cpu.valid & (nmi.ready | expire);
    assign cpu.rdata = own_cpu ? (expire ? ERR_RDATA : nmi.rdata) : '0;
    assign dma.ready = own_dma & dma.valid & (nmi.ready | expire);
    assign dma.rdata = own_dma ? (expire ? ERR_RDATA : nmi.rdata) : '0;

    assign grant_o[OWN_CPU_BIT] = own_cpu;
    assign grant_o[OWN_DMA_BIT] = own_dma;

    always_comb begin
        state_next    = state_reg;
        last_dma_next = last_dma_reg;
        case (state_reg)
            IDLE: begin
                // On a tie the master that did not own the bus last goes first.
                if (cpu.valid && (!dma.valid || last_dma_reg)) begin
                    state_next = OWN_CPU;
                end else if (dma.valid) begin
                    state_next = OWN_DMA;
                end
            end
            OWN_CPU, OWN_DMA: begin
                if (leave) begin
                    state_next    = IDLE;
                    last_dma_next = own_dma;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            last_dma_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            last_dma_reg <= last_dma_next;
        end
    end

`ifdef NMI_BUS_ARB_TIMEOUT_EN
    logic              wdog_start;
    logic              wdog_busy;
    logic              err_reg;
    logic [NMI_AW-1:0] err_addr_reg;

    assign wdog_start = (state_reg == IDLE) & (state_next != IDLE);
    assign wdog_busy  = x_valid & ~nmi.ready;

    nmi_bus_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (wdog_start),
        .busy   (wdog_busy),
        .done   (leave),
        .expire (expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
        end else if (expire) begin
            err_reg      <= 1'b1;
            err_addr_reg <= own_dma ? dma.addr : cpu.addr;
        end else if (err_clr_i) begin
            err_reg <= 1'b0;
        end
    end

    assign err_o      = err_reg;
    assign err_addr_o = err_addr_reg;
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign err_o      = 1'b0;
    assign err_addr_o = '0;
    assign unused_cfg = ^{err_clr_i, 16'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_nmi_bus_arb.sv
// Randomized and directed bench for nmi_bus_arb against a transaction-level reference model.
// Timeout scenarios are exercised when NMI_BUS_ARB_TIMEOUT_EN is defined.
module tb_nmi_bus_arb;
    import nmi_bus_arb_pkg::*;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
`ifdef NMI_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic [1:0]  grant;
    logic        err;
    logic [31:0] err_addr;

    nmi_if cpu_bus ();
    nmi_if dma_bus ();
    nmi_if nmi_bus ();

    nmi_bus_arb #(
        .TIMEOUT_CYC (TO),
        .ERR_RDATA   (ERR_VAL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpu        (cpu_bus),
        .dma        (dma_bus),
        .nmi        (nmi_bus),
        .grant_o    (grant),
        .err_o      (err),
        .err_addr_o (err_addr),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // master intent: index 0 = cpu, 1 = dma
    bit          m_valid [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    int          m_left  [2];
    bit          m_rand  = 0;

    // slave behaviour
    bit          slave_rand = 0;
    bit          hang       = 0;
    int          lat        = 1;
    bit          fix_rd     = 0;
    logic [31:0] fix_rdata  = '0;
    bit          clr_req    = 0;

    // reference model: owner 0 none / 1 cpu / 2 dma
    int          own       = 0;
    int          last      = 2;
    int          wait_cnt  = 0;
    int          valid_cnt = 0;
    bit          e_err     = 0;
    logic [31:0] e_err_addr = '0;
    int          grants[$];

    // values observed on the most recent step
    logic [1:0]  obs_grant;
    logic        obs_cready, obs_dready, obs_err;
    logic [31:0] obs_crd, obs_drd, obs_err_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_payload(input int i);
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
        m_wstrb[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [3:0] s, input int n);
        m_valid[i] = 1'b1;
        m_addr[i]  = a;
        m_wdata[i] = $urandom;
        m_wstrb[i] = s;
        m_left[i]  = n;
    endtask

    task automatic model_reset();
        own = 0; last = 2; wait_cnt = 0; valid_cnt = 0;
        e_err = 1'b0; e_err_addr = '0;
    endtask

    task automatic apply_inputs();
        cpu_bus.valid = m_valid[0]; cpu_bus.addr = m_addr[0];
        cpu_bus.wdata = m_wdata[0]; cpu_bus.wstrb = m_wstrb[0];
        dma_bus.valid = m_valid[1]; dma_bus.addr = m_addr[1];
        dma_bus.wdata = m_wdata[1]; dma_bus.wstrb = m_wstrb[1];
        err_clr = clr_req;
    endtask

    // One clock cycle: drive at negedge, check, clock, advance model, return at next negedge.
    task automatic step();
        bit          xv, rdy, tmo, e_nv, e_cr, e_dr;
        logic [31:0] rd, e_crd, e_drd;
        logic [1:0]  e_grant;
        int          xi;
        apply_inputs();
        xi  = (own == 2) ? 1 : 0;
        xv  = (own != 0) && m_valid[xi];
        rdy = xv && !hang && (slave_rand ? ($urandom_range(0, 99) < 35) : (valid_cnt >= lat));
        rd  = fix_rd ? fix_rdata : $urandom;
        nmi_bus.ready = rdy;
        nmi_bus.rdata = rd;
        tmo     = TO_EN && xv && !rdy && (wait_cnt == TO - 1);
        e_nv    = xv && !tmo;
        e_cr    = (own == 1) && m_valid[0] && (rdy || tmo);
        e_dr    = (own == 2) && m_valid[1] && (rdy || tmo);
        e_crd   = (own == 1) ? (tmo ? ERR_VAL : rd) : 32'h0;
        e_drd   = (own == 2) ? (tmo ? ERR_VAL : rd) : 32'h0;
        e_grant = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
        #1;
        chk("grant", grant, e_grant);
        chk("nmi_valid", nmi_bus.valid, e_nv);
        chk("cpu_ready", cpu_bus.ready, e_cr);
        chk("dma_ready", dma_bus.ready, e_dr);
        chk("cpu_rdata", cpu_bus.rdata, e_crd);
        chk("dma_rdata", dma_bus.rdata, e_drd);
        chk("err", err, e_err);
        chk("err_addr", err_addr, e_err_addr);
        if (e_nv) begin
            chk("nmi_addr", nmi_bus.addr, m_addr[xi]);
            chk("nmi_wdata", nmi_bus.wdata, m_wdata[xi]);
            chk("nmi_wstrb", nmi_bus.wstrb, m_wstrb[xi]);
        end
        obs_grant = grant; obs_cready = cpu_bus.ready; obs_dready = dma_bus.ready;
        obs_crd = cpu_bus.rdata; obs_drd = dma_bus.rdata;
        obs_err = err; obs_err_addr = err_addr;
        if (e_cr || e_dr)
            $display("[TB] %0t %s %s addr=%h rdata=%h%s", $time, e_cr ? "cpu" : "dma",
                     (m_wstrb[xi] == 4'h0) ? "rd" : "wr", m_addr[xi], e_cr ? e_crd : e_drd,
                     tmo ? " timeout" : "");
        @(posedge clk);
        if (own == 0) begin
            if (m_valid[0] && (!m_valid[1] || last == 2)) own = 1;
            else if (m_valid[1]) own = 2;
            if (own != 0) begin
                wait_cnt = 0; valid_cnt = 0;
                grants.push_back(own);
            end
        end else if (!xv || rdy || tmo) begin
            last = own;
            own  = 0;
        end else begin
            wait_cnt++;
            valid_cnt++;
        end
        if (tmo) begin
            e_err = 1'b1;
            e_err_addr = m_addr[xi];
        end else if (clr_req) begin
            e_err = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if ((i == 0) ? e_cr : e_dr) begin
                m_left[i]--;
                if (m_left[i] > 0) new_payload(i);
                else m_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
        if (m_rand) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_valid[i] && $urandom_range(0, 3) == 0) begin
                    m_valid[i] = 1'b1; m_left[i] = 1; new_payload(i);
                end else if (m_valid[i] && $urandom_range(0, 49) == 0) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ready_at;
        int last_rdy;
        bit seen;

        rst = 1'b1;
        clr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b1; m_addr[i] = 32'h0; m_wdata[i] = 32'h0;
            m_wstrb[i] = 4'h0; m_left[i] = 0;
        end
        apply_inputs();
        nmi_bus.ready = 1'b1;
        nmi_bus.rdata = 32'hFFFF_FFFF;
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_nmi_valid", nmi_bus.valid, 1'b0);
        chk("rst_cpu_ready", cpu_bus.ready, 1'b0);
        chk("rst_dma_ready", dma_bus.ready, 1'b0);
        chk("rst_cpu_rdata", cpu_bus.rdata, 32'h0);
        chk("rst_dma_rdata", dma_bus.rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_addr", err_addr, 32'h0);
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        @(negedge clk);
        do_reset();

        // cpu read alone, slave ready after 3 wait cycles
        lat = 3; fix_rd = 1'b1; fix_rdata = 32'h1234_5678;
        req(0, 32'h1000_0000, 4'h0, 1);
        ready_at = -1; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 1) chk("t1_grant_cyc1", obs_grant, 2'b01);
            if (obs_cready && ready_at < 0) begin
                ready_at = k;
                chk("t1_rdata", obs_crd, 32'h1234_5678);
            end
            if (obs_dready) seen = 1'b1;
        end
        chk("t1_ready_cyc", ready_at, 4);
        chk("t1_dma_ready", seen, 1'b0);
        fix_rd = 1'b0;

        // continuous contention from reset: strict alternation
        do_reset();
        lat = 1;
        grants.delete();
        req(0, $urandom, 4'h0, 4);
        req(1, $urandom, 4'hF, 4);
        last_rdy = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (obs_cready || obs_dready) last_rdy = k;
        end
        chk("t2_ngrants", grants.size(), 8);
        for (int g = 0; g < 8 && g < grants.size(); g++)
            chk($sformatf("t2_grant%0d", g), grants[g], (g % 2 == 0) ? 1 : 2);
        chk("t2_last_ready_cyc", last_rdy, 23);

        // dma write in flight, cpu raises valid mid-transfer
        lat = 3;
        req(1, 32'h4000_0010, 4'hF, 1);
        for (int k = 0; k < 10; k++) begin
            if (k == 2) req(0, $urandom, 4'h0, 1);
            step();
            if (k == 4) chk("t3_dma_ready_cyc4", obs_dready, 1'b1);
            if (k == 5) chk("t3_idle_gap", obs_grant, 2'b00);
            if (k == 6) chk("t3_cpu_grant_cyc6", obs_grant, 2'b01);
        end
        drain(6);

`ifdef NMI_BUS_ARB_TIMEOUT_EN
        // hung slave: forced termination on the TO-th owned cycle
        hang = 1'b1;
        req(0, 32'h5000_0000, 4'h0, 1);
        for (int k = 0; k < 12; k++) begin
            clr_req = (k == 9);
            step();
            if (k == 8) begin
                chk("t4_cpu_ready_cyc8", obs_cready, 1'b1);
                chk("t4_err_rdata", obs_crd, ERR_VAL);
            end
            if (k == 9) begin
                chk("t4_err_set", obs_err, 1'b1);
                chk("t4_err_addr", obs_err_addr, 32'h5000_0000);
            end
            if (k == 10) chk("t4_err_cleared", obs_err, 1'b0);
        end
        clr_req = 1'b0;
        hang = 1'b0;
`endif

        // asynchronous reset while dma owns the bus
        lat = 5;
        req(1, $urandom, 4'h3, 1);
        step();
        step();
        chk("t5_own_dma", obs_grant, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_nmi_valid", nmi_bus.valid, 1'b0);
        chk("t5_async_grant", grant, 2'b00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        req(0, $urandom, 4'h0, 1);
        step();
        step();
        chk("t5_cpu_first", obs_grant, 2'b01);
        drain(20);

        // dma withdraws its request before ready, cpu pending
        lat = 5;
        seen = 1'b0;
        req(1, $urandom, 4'h0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) req(0, $urandom, 4'h0, 1);
            if (k == 3) m_valid[1] = 1'b0;
            step();
            if (obs_dready) seen = 1'b1;
            if (k == 4) chk("t6_idle_after_abort", obs_grant, 2'b00);
            if (k == 5) chk("t6_cpu_next", obs_grant, 2'b01);
        end
        chk("t6_no_dma_ready", seen, 1'b0);
        drain(10);

        // randomized traffic with occasional hung slave and error clears
        slave_rand = 1'b1;
        m_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            clr_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) hang = ~hang;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
